queue_rr_scheduler: RTL

Round-robin scheduler that drains up to NREQ delay queues into one shared downstream consumer. Each cycle it selects at most one non-empty, enabled source and pops its head with a one-hot read strobe. The popped word goes into a single output register with a valid/ready handshake. A per-source burst quantum lets a source keep the grant for up to QUANTUM consecutive pops before the scheduler rotates.

---
 rtl/queue_rr_scheduler.sv | 112 +++++++++++
 1 files changed

// File: rtl/queue_rr_scheduler.sv
// Round-robin scheduler draining NREQ source queues into one registered output,
// letting a granted source keep the grant for up to QUANTUM consecutive pops.
module queue_rr_scheduler #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int SRCW    = 2,
    parameter int QUANTUM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       src_valid,
    input  logic [NREQ*WIDTH-1:0] src_data,
    output logic [NREQ-1:0]       src_re,
    input  logic [NREQ-1:0]       src_enable,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SRCW-1:0]       out_src,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_nxt;
    logic [SRCW-1:0] cur, cur_nxt, ptr, ptr_nxt;
    logic [CW-1:0]   burst_cnt, cnt_nxt;
    logic [NREQ-1:0] elig;
    logic            load, keep, found, grant;
    logic [SRCW-1:0] found_idx, grant_idx;

    assign elig = src_valid & src_enable;
    assign load = ~out_valid | out_ready;
    assign keep = (state == BURST) && elig[cur] && (int'(burst_cnt) < QUANTUM - 1);

    // Search starts just after ptr, so the current holder is considered last and
    // is only regranted when nobody else is eligible.
    always_comb begin
        int              idx;
        logic [SRCW-1:0] j;
        found     = 1'b0;
        found_idx = '0;
        idx       = 0;
        j         = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            j   = SRCW'(idx);
            if (!found && elig[j]) begin
                found     = 1'b1;
                found_idx = j;
            end
        end
    end

    // No pops while reset is held, even though the reset state looks idle.
    assign grant     = rst & load & (keep | found);
    assign grant_idx = keep ? cur : found_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cur       <= '0;
            ptr       <= SRCW'(NREQ - 1);
            burst_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            state     <= state_nxt;
            cur       <= cur_nxt;
            ptr       <= ptr_nxt;
            burst_cnt <= cnt_nxt;
            if (load) begin
                if (grant) begin
                    out_valid <= 1'b1;
                    out_data  <= src_data[int'(grant_idx)*WIDTH +: WIDTH];
                    out_src   <= grant_idx;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        ptr_nxt   = ptr;
        cnt_nxt   = burst_cnt;
        if (load) begin
            if (keep) begin
                cnt_nxt = burst_cnt + CW'(1);
            end else if (found) begin
                state_nxt = BURST;
                cur_nxt   = found_idx;
                ptr_nxt   = found_idx;
                cnt_nxt   = '0;
            end else begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        end
    end

    always_comb begin
        src_re = '0;
        if (grant) src_re[grant_idx] = 1'b1;
        busy = (state == BURST) || out_valid;
    end

endmodule
